// File: rtl/line_stream_buffer_pkg.sv
// Shared types for the ping-pong line buffer between the line engine and the video stream.
package line_stream_buffer_pkg;

    localparam int ARM_TIMEOUT         = 8;
    localparam int DEPTH_WIDTH_DEFAULT = 10;

    typedef logic [DEPTH_WIDTH_DEFAULT-1:0] depth_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_START,
        F_ARM,
        F_FILL,
        F_COMMIT
    } fill_state_t;

    typedef enum logic {
        D_IDLE,
        D_STREAM
    } drain_state_t;

endpackage

// File: rtl/line_stream_buffer_bank_ram.sv
// One line bank: simple dual-port RAM with registered read, written by the fill side, read by the drain side.
module line_bank_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 10,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_stream_buffer.sv
// Captures engine depth writes into two line banks and streams completed lines as valid/ready beats.
module line_stream_buffer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int DEPTH_WIDTH   = 10,
    parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    output logic                   eng_start,
    input  logic                   eng_done,
    input  logic [DEPTH_WIDTH-1:0] depth_in,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic                   we_in,
    output logic [DEPTH_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tuser,
    output logic                   m_tlast,
    output logic                   line_err
);
    import line_stream_buffer_pkg::*;

    localparam int CNT_WIDTH = $clog2(SCREEN_WIDTH + 2);
    localparam int TMR_WIDTH = $clog2(ARM_TIMEOUT + 1);
    localparam int Y_WIDTH   = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int BEAT_W    = DEPTH_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_X = ADDR_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0]    LAST_Y = Y_WIDTH'(SCREEN_HEIGHT - 1);

    fill_state_t            fill_state, fill_next;
    drain_state_t           drain_state, drain_next;
    logic                   fill_bank, rd_bank, drain_bank;
    logic [1:0]             full;
    logic [CNT_WIDTH-1:0]   wr_cnt;
    logic [TMR_WIDTH-1:0]   arm_cnt;
    logic                   wr_en, addr_ok, commit, last_accept;
    logic [ADDR_WIDTH-1:0]  rd_x;
    logic [Y_WIDTH-1:0]     y_drain;
    logic                   rd_issue, space_ok, pop;
    logic                   rd_v, rd_v_bank, rd_v_user, rd_v_last;
    logic [DEPTH_WIDTH-1:0] bank_rdata [2];
    logic [BEAT_W-1:0]      rd_beat, sk0, sk1;
    logic [1:0]             sk_cnt;

    assign addr_ok = {1'b0, addr_in} < (ADDR_WIDTH + 1)'(SCREEN_WIDTH);
    assign wr_en   = (fill_state == F_FILL) && we_in && addr_ok;
    assign commit  = (fill_state == F_COMMIT);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank_ram #(
            .DEPTH (SCREEN_WIDTH),
            .WIDTH (DEPTH_WIDTH),
            .AW    (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en && (fill_bank == 1'(b))),
            .waddr (addr_in),
            .wdata (depth_in),
            .re    (rd_issue && (rd_bank == 1'(b))),
            .raddr (rd_x),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        fill_next = fill_state;
        eng_start = 1'b0;
        case (fill_state)
            F_IDLE:   if (run && !full[fill_bank] && eng_done) fill_next = F_START;
            F_START: begin
                eng_start = 1'b1;
                fill_next = F_ARM;
            end
            F_ARM: begin
                if (!eng_done) fill_next = F_FILL;
                else if (arm_cnt == TMR_WIDTH'(ARM_TIMEOUT - 1)) fill_next = F_IDLE;
            end
            F_FILL:   if (eng_done) fill_next = F_COMMIT;
            F_COMMIT: fill_next = F_IDLE;
            default:  fill_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_state <= F_IDLE;
            fill_bank  <= 1'b0;
            wr_cnt     <= '0;
            arm_cnt    <= '0;
            line_err   <= 1'b0;
        end else begin
            fill_state <= fill_next;
            case (fill_state)
                F_START: begin
                    wr_cnt  <= '0;
                    arm_cnt <= '0;
                end
                F_ARM: begin
                    arm_cnt <= arm_cnt + TMR_WIDTH'(1);
                    if (eng_done && arm_cnt == TMR_WIDTH'(ARM_TIMEOUT - 1)) line_err <= 1'b1;
                end
                F_FILL: begin
                    // Out-of-range addresses still count so a short or bad line is flagged.
                    if (we_in && wr_cnt != CNT_WIDTH'(SCREEN_WIDTH + 1)) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
                end
                F_COMMIT: begin
                    fill_bank <= ~fill_bank;
                    if (wr_cnt != CNT_WIDTH'(SCREEN_WIDTH)) line_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (commit && fill_bank == 1'(b)) full[b] <= 1'b1;
                else if (last_accept && drain_bank == 1'(b)) full[b] <= 1'b0;
            end
        end
    end

    // Reads run ahead of acceptance into a 2-entry skid; issue only if the beat is sure to fit.
    assign pop         = m_tvalid && m_tready;
    assign space_ok    = (sk_cnt + {1'b0, rd_v}) <= ({1'b0, pop} + 2'd1);
    assign last_accept = pop && sk0[DEPTH_WIDTH];

    always_comb begin
        drain_next = drain_state;
        rd_issue   = 1'b0;
        case (drain_state)
            D_IDLE: begin
                if (full[rd_bank] && space_ok) begin
                    rd_issue   = 1'b1;
                    drain_next = D_STREAM;
                end
            end
            D_STREAM: begin
                if (space_ok) begin
                    rd_issue = 1'b1;
                    if (rd_x == LAST_X) drain_next = D_IDLE;
                end
            end
            default: drain_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_state <= D_IDLE;
            rd_bank     <= 1'b0;
            drain_bank  <= 1'b0;
            rd_x        <= '0;
            y_drain     <= '0;
            rd_v        <= 1'b0;
            rd_v_bank   <= 1'b0;
            rd_v_user   <= 1'b0;
            rd_v_last   <= 1'b0;
        end else begin
            drain_state <= drain_next;
            rd_v        <= rd_issue;
            rd_v_bank   <= rd_bank;
            rd_v_user   <= (rd_x == '0) && (y_drain == '0);
            rd_v_last   <= (rd_x == LAST_X);
            if (rd_issue) begin
                if (rd_x == LAST_X) begin
                    rd_x    <= '0;
                    rd_bank <= ~rd_bank;
                    y_drain <= (y_drain == LAST_Y) ? '0 : y_drain + Y_WIDTH'(1);
                end else begin
                    rd_x <= rd_x + ADDR_WIDTH'(1);
                end
            end
            if (last_accept) drain_bank <= ~drain_bank;
        end
    end

    assign rd_beat = {rd_v_user, rd_v_last, bank_rdata[rd_v_bank]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sk0    <= '0;
            sk1    <= '0;
            sk_cnt <= 2'd0;
        end else begin
            case ({rd_v, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0) sk0 <= rd_beat;
                    else sk1 <= rd_beat;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0    <= sk1;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk0 <= rd_beat;
                    end else begin
                        sk0 <= sk1;
                        sk1 <= rd_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_tvalid = (sk_cnt != 2'd0);
    assign m_tdata  = sk0[DEPTH_WIDTH-1:0];
    assign m_tlast  = m_tvalid && sk0[DEPTH_WIDTH];
    assign m_tuser  = m_tvalid && sk0[DEPTH_WIDTH+1];

endmodule

// File: tb/tb_line_stream_buffer.sv
// Bench for line_stream_buffer: engine model, line-level scoreboard and directed scenarios.
module tb_line_stream_buffer;
    import line_stream_buffer_pkg::*;

    localparam int W  = 640;
    localparam int H  = 4;
    localparam int DW = 10;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n, run, eng_start, eng_done, we_in;
    logic          m_tvalid, m_tready, m_tuser, m_tlast, line_err;
    logic [DW-1:0] depth_in, m_tdata;
    logic [AW-1:0] addr_in;

    always #5 clk = ~clk;

    line_stream_buffer #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .DEPTH_WIDTH   (DW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .depth_in  (depth_in),
        .addr_in   (addr_in),
        .we_in     (we_in),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .line_err  (line_err)
    );

    typedef struct {
        depth_t data;
        bit     dc;
        bit     user;
        bit     last;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  hd;
    int     total = 0, bad = 0;
    int     starts = 0, accepted = 0, cyc = 0, line_pos = 0, g_line = 0;
    int     start_cyc = 0, tlast_cyc = 0, last_span = 0, tuser_cnt = 0;
    int     gap_of_line[32];
    int     start_beats[32];
    depth_t log0[W];
    int     y_model = 0, serial = 0, next_npix = W, tready_mode = 0;
    bit     engine_busy = 1'b0;
    int     s0, a0, u0;

    function automatic depth_t depth_of(input int s, input int x);
        return (s == 0) ? depth_t'(x % 200) : depth_t'((x * 3 + s * 37) % 1024);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input int mode);
        @(posedge clk);
        #1;
        run         = r;
        tready_mode = mode;
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && starts < target; i++) @(negedge clk);
        checkOutput($sformatf("start_count_%0d", target), starts, target);
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && (engine_busy || exp_q.size() != 0 || m_tvalid); i++) @(negedge clk);
        checkOutput("drained", exp_q.size() + int'(engine_busy), 0);
    endtask

    // Engine: answers each start with a shuffled set of writes, then hands the finished line to the model.
    task automatic engine_line();
        int  perm[W];
        int  npix = next_npix;
        int  tmp, j;
        bit  written[W];
        beat_t b;
        engine_busy = 1'b1;
        for (int i = 0; i < W; i++) perm[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        @(posedge clk); #1;
        eng_done = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < npix; i++) begin
            we_in    = 1'b1;
            addr_in  = AW'(perm[i]);
            depth_in = depth_of(serial, perm[i]);
            written[perm[i]] = 1'b1;
            @(posedge clk); #1;
        end
        we_in    = 1'b0;
        eng_done = 1'b1;
        for (int x = 0; x < W; x++) begin
            b.data = depth_of(serial, x);
            b.dc   = !written[x];
            b.user = (x == 0) && (y_model == 0);
            b.last = (x == W - 1);
            exp_q.push_back(b);
        end
        y_model     = (y_model + 1) % H;
        serial++;
        next_npix   = W;
        engine_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && eng_start === 1'b1) engine_line();
        end
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                default: m_tready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Scoreboard: every presented beat must equal the head of the expected stream.
    always @(negedge clk) begin
        cyc++;
        if (reset_n && eng_start) begin
            if (starts < 32) start_beats[starts] = accepted;
            starts++;
        end
        if (reset_n && m_tvalid) begin
            if (exp_q.size() == 0) begin
                checkOutput("expected_beat_available", exp_q.size(), 1);
            end else begin
                hd = exp_q[0];
                if (!hd.dc) checkOutput("tdata", m_tdata, hd.data);
                checkOutput("tuser", m_tuser, hd.user);
                checkOutput("tlast", m_tlast, hd.last);
                if (m_tready) begin
                    void'(exp_q.pop_front());
                    if (accepted < W) log0[accepted] = m_tdata;
                    if (line_pos == 0) begin
                        start_cyc = cyc;
                        if (g_line < 32) gap_of_line[g_line] = cyc - tlast_cyc;
                    end
                    if (m_tuser) tuser_cnt++;
                    if (hd.last) begin
                        tlast_cyc = cyc;
                        last_span = cyc - start_cyc;
                        line_pos  = 0;
                        g_line++;
                    end else begin
                        line_pos++;
                    end
                    accepted++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        run      = 1'b0;
        eng_done = 1'b1;
        we_in    = 1'b0;
        addr_in  = '0;
        depth_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", m_tvalid, 0);
        checkOutput("reset_tuser", m_tuser, 0);
        checkOutput("reset_tlast", m_tlast, 0);
        checkOutput("reset_tdata", m_tdata, 0);
        checkOutput("reset_eng_start", eng_start, 0);
        checkOutput("reset_line_err", line_err, 0);
        reset_n = 1'b1;

        $display("[TB] single line, shuffled writes");
        applyStimulus(1'b1, 0);
        wait_starts(1, 50);
        applyStimulus(1'b0, 0);
        wait_drained(3000);
        checkOutput("t1_starts", starts, 1);
        checkOutput("t1_beats", accepted, 640);
        checkOutput("t1_pin_x0", log0[0], 0);
        checkOutput("t1_pin_x250", log0[250], 50);
        checkOutput("t1_pin_x639", log0[639], 39);
        checkOutput("t1_span", last_span, 639);
        checkOutput("t1_tuser_cnt", tuser_cnt, 1);
        checkOutput("t1_line_err", line_err, 0);

        $display("[TB] stalled stream, both banks fill");
        applyStimulus(1'b1, 1);
        wait_starts(3, 3000);
        for (int i = 0; i < 1000 && engine_busy; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        checkOutput("t2_withheld", starts, 3);
        checkOutput("t2_stalled_valid", m_tvalid, 1);
        checkOutput("t2_stalled_tdata", m_tdata, 37);
        checkOutput("t2_no_accept", accepted, 640);
        applyStimulus(1'b1, 0);
        wait_starts(4, 3000);
        applyStimulus(1'b0, 0);
        checkOutput("t2_third_start_after_tlast", start_beats[3] >= 1280, 1);
        wait_drained(4000);
        checkOutput("t2_beats", accepted, 640 * 4);
        checkOutput("t2_no_bubble_gap", gap_of_line[2], 1);

        $display("[TB] random backpressure over three lines");
        applyStimulus(1'b1, 2);
        wait_starts(7, 8000);
        applyStimulus(1'b0, 2);
        wait_drained(8000);
        checkOutput("t3_beats", accepted, 640 * 7);
        checkOutput("t3_tuser_cnt", tuser_cnt, 2);
        checkOutput("t3_line_err", line_err, 0);

        $display("[TB] short line sets sticky error");
        next_npix = W - 1;
        applyStimulus(1'b1, 0);
        wait_starts(8, 3000);
        applyStimulus(1'b0, 0);
        wait_drained(3000);
        checkOutput("t4_line_err", line_err, 1);
        applyStimulus(1'b1, 0);
        wait_starts(9, 3000);
        applyStimulus(1'b0, 0);
        wait_drained(3000);
        checkOutput("t4_err_sticky", line_err, 1);
        checkOutput("t4_beats", accepted, 640 * 9);

        $display("[TB] reset in the middle of a line");
        applyStimulus(1'b1, 0);
        wait_starts(10, 3000);
        applyStimulus(1'b0, 0);
        for (int i = 0; i < 3000 && line_pos < 300; i++) @(negedge clk);
        checkOutput("t5_reached_x300", line_pos >= 300, 1);
        @(posedge clk); #1;
        checkOutput("t5_valid_before", m_tvalid, 1);
        reset_n  = 1'b0;
        exp_q.delete();
        y_model  = 0;
        line_pos = 0;
        #1;
        checkOutput("t5_valid_async", m_tvalid, 0);
        checkOutput("t5_err_cleared", line_err, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        a0 = accepted;
        u0 = tuser_cnt;
        applyStimulus(1'b1, 0);
        wait_starts(11, 3000);
        applyStimulus(1'b0, 0);
        wait_drained(3000);
        checkOutput("t5_beats", accepted - a0, 640);
        checkOutput("t5_tuser", tuser_cnt - u0, 1);

        $display("[TB] five lines over a four-line frame");
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        y_model  = 0;
        line_pos = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        s0 = starts;
        a0 = accepted;
        u0 = tuser_cnt;
        applyStimulus(1'b1, 0);
        wait_starts(s0 + 5, 8000);
        applyStimulus(1'b0, 0);
        wait_drained(5000);
        repeat (100) @(negedge clk);
        checkOutput("t6_starts", starts - s0, 5);
        checkOutput("t6_beats", accepted - a0, 640 * 5);
        checkOutput("t6_tuser", tuser_cnt - u0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
